// File: rtl/cordic_pkg.sv
// Shared definitions for the round-robin CORDIC multiplier scheduler.
// Holds the scheduler state encoding, the default operand/result widths and
// the nominal start-to-done latency of the shared multiplier core.
package cordic_pkg;

    localparam int DW            = 8;   // signed operand width (x, z)
    localparam int YW            = 16;  // result width
    localparam int CORE_DONE_LAT = 1;   // core_done follows the sampled start by this many cycles

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Picks the first asserted request at or above ptr, wrapping modulo NREQ.
// Ports:
//   req       in  NREQ  request vector
//   ptr       in  PW    highest-priority requester index
//   grant     out NREQ  one-hot grant (all zero when nothing requests)
//   grant_idx out PW    index of the granted requester (0 when none)
//   grant_any out 1     at least one request present
module cordic_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    // Rotating priority search starting at ptr; the first hit wins.
    always_comb begin : arb_search
        logic [PW-1:0] cand_v;
        logic          hit_v;
        cand_v    = '0;
        hit_v     = 1'b0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_v    = PW'((int'(ptr) + k) % NREQ);
            hit_v     = req[cand_v] & ~grant_any;
            grant_idx = hit_v ? cand_v : grant_idx;
            grant_any = grant_any | req[cand_v];
        end
        grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/cordic_mul_rr_sched.sv
// Round-robin scheduler sharing one CORDIC multiplier core among NREQ
// requesters. One transaction is in flight at a time:
// IDLE (arbitrate/accept) -> ISSUE (start pulse) -> WAIT (core or watchdog)
// -> RESP (hold response until the owner accepts it).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester request handshake (ready only in IDLE)
//   req_x, req_z          packed signed operands, requester i at [i*DW +: DW]
//   rsp_valid/rsp_ready   one-hot response handshake to the owner
//   rsp_y, rsp_err        shared result bus; rsp_err=1 means watchdog expiry, rsp_y=0
//   core_start/x/z        start pulse and operands to the external core
//   core_y, core_done     result and done strobe from the external core
//   op_count              completed transactions (errors included), wraps
module cordic_mul_rr_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = cordic_pkg::DW,
    parameter int YW      = cordic_pkg::YW,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_x,
    input  logic [NREQ*DW-1:0]   req_z,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [YW-1:0]        rsp_y,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [DW-1:0]        core_x,
    output logic [DW-1:0]        core_z,
    input  logic [YW-1:0]        core_y,
    input  logic                 core_done,
    output logic [15:0]          op_count
);

    import cordic_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // A watchdog shorter than the nominal core latency would flag healthy cores.
    localparam int TO_EFF = (TIMEOUT > CORE_DONE_LAT) ? TIMEOUT : (CORE_DONE_LAT + 1);
    localparam int CW = $clog2(TO_EFF + 1);

    sched_state_t      state_r,   state_nxt_s;
    logic [PW-1:0]     ptr_r,     ptr_nxt_s;
    logic [PW-1:0]     owner_r,   owner_nxt_s;
    logic [DW-1:0]     x_r,       x_nxt_s;
    logic [DW-1:0]     z_r,       z_nxt_s;
    logic [CW-1:0]     wd_cnt_r,  wd_nxt_s;
    logic [CW-1:0]     wd_inc_s;
    logic [YW-1:0]     y_r,       y_nxt_s;
    logic              err_r,     err_nxt_s;
    logic [NREQ-1:0]   rsp_valid_r;
    logic              core_start_r;
    logic [15:0]       op_count_r;
    logic              txn_done_s;
    logic [NREQ-1:0]   grant_s;
    logic [PW-1:0]     grant_idx_s;
    logic              grant_any_s;

    cordic_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign wd_inc_s   = wd_cnt_r + CW'(1);
    // Accepting only in IDLE keeps a single transaction in flight.
    assign req_ready  = (state_r == IDLE) ? grant_s : '0;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_y      = y_r;
    assign rsp_err    = err_r;
    assign core_start = core_start_r;
    assign core_x     = x_r;
    assign core_z     = z_r;
    assign op_count   = op_count_r;

    // Next-state and datapath-capture decisions for the scheduler FSM.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        x_nxt_s     = x_r;
        z_nxt_s     = z_r;
        wd_nxt_s    = wd_cnt_r;
        y_nxt_s     = y_r;
        err_nxt_s   = err_r;
        txn_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    // Operands are sampled only on the accepting edge.
                    owner_nxt_s = grant_idx_s;
                    x_nxt_s     = req_x[grant_idx_s*DW +: DW];
                    z_nxt_s     = req_z[grant_idx_s*DW +: DW];
                    ptr_nxt_s   = (grant_idx_s == PW'(NREQ - 1)) ? '0 : (grant_idx_s + PW'(1));
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                wd_nxt_s    = '0;
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    y_nxt_s     = core_y;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = RESP;
                end else if (wd_inc_s == CW'(TO_EFF)) begin
                    y_nxt_s     = '0;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    wd_nxt_s    = wd_inc_s;
                end
            end
            RESP: begin
                // Only the owner's ready bit can complete the response.
                if (rsp_ready[owner_r]) begin
                    txn_done_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, captured operands/result and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            owner_r      <= '0;
            x_r          <= '0;
            z_r          <= '0;
            wd_cnt_r     <= '0;
            y_r          <= '0;
            err_r        <= 1'b0;
            rsp_valid_r  <= '0;
            core_start_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            owner_r      <= owner_nxt_s;
            x_r          <= x_nxt_s;
            z_r          <= z_nxt_s;
            wd_cnt_r     <= wd_nxt_s;
            y_r          <= y_nxt_s;
            err_r        <= err_nxt_s;
            // Strobes decoded from the next state so they appear registered.
            core_start_r <= (state_nxt_s == ISSUE);
            rsp_valid_r  <= (state_nxt_s == RESP) ? (NREQ'(1) << owner_nxt_s) : '0;
        end
    end

    // Completed-transaction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= 16'd0;
        end else if (txn_done_s) begin
            op_count_r <= op_count_r + 16'd1;
        end else begin
            op_count_r <= op_count_r;
        end
    end

endmodule
